// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle ADD/SUB/logic/SLT/MOV and a WIDTH-step shift-add MUL,
// valid/ready handshaked, with synchronous kill and asynchronous reset.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLT = 3'd5, OP_MOV = 3'd6, OP_MUL = 3'd7
  } op_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;

  logic [WIDTH-1:0]     sum, diff, alu_res;
  logic                 alu_ovf;
  logic [2*WIDTH-1:0]   acc_sum;

  always_comb begin
    sum     = src1 + src2;
    diff    = src1 - src2;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_MOV:  alu_res = src1;
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (kill) begin
      // Abort discards the partial product but keeps the visible result/flags.
      state_d  = IDLE;
      cnt_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      acc_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              state_d  = BUSY;
              cnt_d    = CNT_W'(WIDTH);
              mcand_d  = {{WIDTH{1'b0}}, src1};
              mplier_d = src2;
              acc_d    = '0;
            end else begin
              state_d  = DONE;
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              ovf_d    = alu_ovf;
            end
          end
        end
        BUSY: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = acc_sum[WIDTH-1:0];
            zero_d   = (acc_sum[WIDTH-1:0] == '0);
            ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;

  int passed = 0;
  int total  = 0;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request for exactly one edge, then scramble the operands.
  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    tick();
    in_valid = 1'b0;
    op       = 3'd0;
    src1     = $urandom;
    src2     = $urandom;
  endtask

  // Cycles from accept edge (counted as 1) until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  int lat;
  logic [WIDTH-1:0] held;

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    kill = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    tick();
    tick();
    reset = 1'b0;

    // ADD signed overflow, latency 1
    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_valid", out_valid, 1);
    check("add_result", result, 32'h8000_0000);
    check("add_ovf", overflow, 1);
    check("add_zero", zero, 0);
    check("add_in_ready", in_ready, 0);
    tick();
    check("add_release", in_ready, 1);
    check("add_valid_drop", out_valid, 0);

    issue(3'd1, 32'h5, 32'h5);
    check("sub_result", result, 0);
    check("sub_zero", zero, 1);
    check("sub_ovf", overflow, 0);
    tick();

    issue(3'd5, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt_result", result, 1);
    check("slt_ovf", overflow, 0);
    tick();

    issue(3'd4, 32'hF0F0_1234, 32'h0F0F_1234);
    check("xor_result", result, 32'hFFFF_0000);
    tick();

    // MUL with high-half overflow, low half zero
    issue(3'd7, 32'h0001_0000, 32'h0001_0000);
    check("mul1_busy", busy, 1);
    wait_valid(lat);
    check("mul1_latency", lat, 33);
    check("mul1_result", result, 0);
    check("mul1_ovf", overflow, 1);
    check("mul1_zero", zero, 1);
    tick();

    // MUL zero operand: no early exit
    issue(3'd7, 32'h0, 32'h5);
    wait_valid(lat);
    check("mul0_latency", lat, 33);
    check("mul0_zero", zero, 1);
    check("mul0_ovf", overflow, 0);
    tick();

    // MUL with backpressure held in DONE
    out_ready = 1'b0;
    issue(3'd7, 32'h0000_FFFF, 32'h0000_0003);
    wait_valid(lat);
    check("mul2_latency", lat, 33);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 32'h0002_FFFD);
      check("bp_ovf", overflow, 0);
      check("bp_zero", zero, 0);
    end
    // Request presented in the releasing cycle must not be accepted
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd0; src1 = 32'h10; src2 = 32'h20;
    tick();
    check("rel_in_ready", in_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_result_hold", result, 32'h0002_FFFD);
    tick();
    in_valid = 1'b0;
    check("issue2_valid", out_valid, 1);
    check("issue2_result", result, 32'h30);
    tick();

    // Kill at cycle 10 of a MUL
    issue(3'd7, 32'h5, 32'h7);
    for (int i = 0; i < 9; i++) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_in_ready", in_ready, 1);
    held = result;
    check("kill_result_hold", held, 32'h30);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) lat++;
    end
    check("kill_no_valid", lat, 0);
    // Kill beats accept
    kill = 1'b1; in_valid = 1'b1; op = 3'd0; src1 = 32'h1; src2 = 32'h1;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    check("kill_vs_accept", busy, 0);
    issue(3'd0, 32'h2, 32'h3);
    check("post_kill_valid", out_valid, 1);
    check("post_kill_result", result, 5);
    tick();

    // Asynchronous reset mid-MUL
    issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_zero", zero, 1);
    check("arst_ovf", overflow, 0);
    tick();
    reset = 1'b0;
    issue(3'd0, 32'h1, 32'h1);
    check("after_rst_valid", out_valid, 1);
    check("after_rst_result", result, 2);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, operand/result width; legal values are 8 to 64.
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MOV (src1), 7 MUL (unsigned).
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B.
- kill  in  1  synchronous abort of the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- zero  out  1  result equals 0.
- overflow  out  1  arithmetic overflow flag.
- busy  out  1  state is not IDLE.

Function
REQ-003 Block SHALL be an FSM with states IDLE, BUSY, DONE.
REQ-004 in_ready SHALL equal (state==IDLE) combinationally; busy SHALL equal (state!=IDLE).
REQ-005 Accept SHALL occur on an edge with in_valid && in_ready && !kill; op, src1 and src2 SHALL be captured at that edge, and later input changes SHALL have no effect.
REQ-006 Ops 0-6 SHALL compute in the accept cycle, register result and flags at the accept edge, go IDLE->DONE, and assert out_valid one cycle after accept (latency 1).
REQ-007 MUL SHALL go IDLE->BUSY, run WIDTH shift-add iterations (one per cycle) with a counter loaded to WIDTH and decremented each edge, then enter DONE; out_valid SHALL assert WIDTH+1 cycles after accept.
REQ-008 The MUL product SHALL be 2*WIDTH bits internally; result SHALL be its low WIDTH bits; overflow SHALL be 1 iff the high WIDTH bits are nonzero.
REQ-009 ADD/SUB result SHALL wrap modulo 2^WIDTH; overflow SHALL be 1 iff signed overflow occurs:
- ADD: operands have equal sign and result sign differs from src1.
- SUB: operands have different sign and result sign differs from src1.
REQ-010 AND, OR, XOR, SLT and MOV SHALL set overflow=0; SLT result SHALL be 1 if $signed(src1) < $signed(src2), else 0.
REQ-011 zero SHALL be 1 iff the registered result is all zeros, for every op.
REQ-012 In DONE, result, zero and overflow SHALL hold stable while out_ready=0 and the FSM SHALL stay in DONE.
REQ-013 In DONE with out_ready=1, the FSM SHALL go to IDLE at the next edge; no new request is accepted in that same cycle, so the minimum issue interval is 2 cycles.
REQ-014 kill=1 SHALL force the FSM to IDLE at the next edge from any state, clear out_valid, and discard any partial product.
REQ-015 kill SHALL take priority over accept and over out_ready; result, zero and overflow SHALL hold their last values after a kill.
REQ-016 A MUL with src1=0 or src2=0 SHALL still take the full WIDTH+1 cycle latency (no early exit).

Reset
REQ-017 While reset=1, regardless of clk:
- state SHALL be IDLE.
- counter SHALL be 0.
- result SHALL be 0; zero SHALL be 1; overflow SHALL be 0.
- out_valid SHALL be 0; in_ready SHALL be 1; busy SHALL be 0.
REQ-018 Reset asserted mid-MUL or in DONE SHALL abandon the operation with no out_valid pulse; the first accept SHALL be possible on the first edge after reset deasserts.

Verification (WIDTH=32)
REQ-019 The bench SHALL cover these scenarios:
- ADD 0x7FFFFFFF + 0x00000001 -> 1 cycle later out_valid=1, result 0x80000000, overflow=1, zero=0.
- SUB 0x00000005 - 0x00000005 -> result 0, zero=1, overflow=0; SLT 0xFFFFFFFF, 0x00000001 -> result 1.
- MUL 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after accept, result 0, overflow=1, zero=1; MUL 0x0000FFFF * 0x00000003 -> 0x0002FFFD, overflow=0.
- Backpressure: out_ready=0 for 4 cycles in DONE -> result and flags stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- Kill at cycle 10 of a MUL -> IDLE next edge, no out_valid; a following ADD 2+3 -> result 5 with latency 1.
- Reset asserted asynchronously mid-MUL -> outputs at their REQ-017 values immediately; after release, a new request is accepted on the first edge.
